// File: rtl/ms_timer.sv
// Millisecond timer: synchronizes the divided clock, emits one-cycle ticks, counts them, and runs
// a start/stop countdown with optional auto-reload.
module ms_timer #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clk_1ms_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             auto_reload_i,
    input  logic [CNT_W-1:0] period_i,
    output logic             tick_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] remaining_o,
    output logic [CNT_W-1:0] ms_cnt_o
);

    localparam int unsigned ArmW = $clog2(SYNC_STAGES + 2);

    typedef enum logic {StIdle, StRun} state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [ArmW-1:0]        arm_q;
    logic                   armed;
    logic                   rise;
    logic                   tick_q;
    logic [CNT_W-1:0]       ms_cnt_q;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       rem_q, rem_d;
    logic                   expire;
    logic                   done_pend_q;
    logic                   done_q;

    // Edge detection stays disabled until the synchronizer holds only post-reset samples.
    assign armed = (arm_q == ArmW'(SYNC_STAGES + 1));
    assign rise  = sync_q[SYNC_STAGES-1] & ~prev_q & armed;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q   <= '0;
            prev_q   <= 1'b0;
            arm_q    <= '0;
            tick_q   <= 1'b0;
            ms_cnt_q <= '0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], clk_1ms_i};
            prev_q   <= sync_q[SYNC_STAGES-1];
            if (!armed) begin
                arm_q <= arm_q + ArmW'(1);
            end
            tick_q   <= rise;
            ms_cnt_q <= ms_cnt_q + CNT_W'(tick_q);
        end
    end

    // Countdown state register; done is delayed one extra cycle behind the expiry edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            rem_q       <= '0;
            done_pend_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            done_pend_q <= expire;
            done_q      <= done_pend_q;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        expire  = 1'b0;
        if (stop_i) begin
            state_d = StIdle;
            rem_d   = '0;
        end else if (start_i) begin
            if (period_i == '0) begin
                state_d = StIdle;
                rem_d   = '0;
                expire  = 1'b1;
            end else begin
                state_d = StRun;
                rem_d   = period_i;
            end
        end else if (state_q == StRun && tick_q) begin
            if (rem_q == CNT_W'(1)) begin
                expire = 1'b1;
                if (auto_reload_i && period_i != '0) begin
                    rem_d = period_i;
                end else begin
                    state_d = StIdle;
                    rem_d   = '0;
                end
            end else begin
                rem_d = rem_q - CNT_W'(1);
            end
        end
    end

    always_comb begin
        busy_o      = (state_q == StRun);
        tick_o      = tick_q;
        done_o      = done_q;
        remaining_o = rem_q;
        ms_cnt_o    = ms_cnt_q;
    end

endmodule

// File: tb/tb_ms_timer.sv
// Randomized self-checking bench for ms_timer against a tick/countdown reference model; a second
// 8-bit instance exercises counter wrap cheaply.
module tb_ms_timer;

    logic        clk, rst, clk_1ms, start, stop, auto_reload;
    logic [15:0] period;
    logic        tick, busy, done;
    logic [15:0] remaining, ms_cnt;
    logic        tick8, busy8, done8;
    logic [7:0]  remaining8, ms_cnt8;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int unsigned n_edges;
    bit          s1, s2, s3, s4;
    bit          m_tick, m_run, m_pend, m_done;
    int unsigned m_rem, m_ms;

    // Observed-event counters for directed checks
    int n_tick_seen, n_done_seen, n_busy_seen;
    bit wave_on;
    int ph_left, ph_lo, ph_hi;

    ms_timer u_dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .clk_1ms_i    (clk_1ms),
        .start_i      (start),
        .stop_i       (stop),
        .auto_reload_i(auto_reload),
        .period_i     (period),
        .tick_o       (tick),
        .busy_o       (busy),
        .done_o       (done),
        .remaining_o  (remaining),
        .ms_cnt_o     (ms_cnt)
    );

    ms_timer #(.CNT_W(8)) u_dut8 (
        .clk_i        (clk),
        .rst_i        (rst),
        .clk_1ms_i    (clk_1ms),
        .start_i      (start),
        .stop_i       (stop),
        .auto_reload_i(auto_reload),
        .period_i     (period[7:0]),
        .tick_o       (tick8),
        .busy_o       (busy8),
        .done_o       (done8),
        .remaining_o  (remaining8),
        .ms_cnt_o     (ms_cnt8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        n_edges = 0;
        {s1, s2, s3, s4} = 4'b0;
        m_tick = 0; m_run = 0; m_pend = 0; m_done = 0;
        m_rem = 0; m_ms = 0;
    endfunction

    // One clk posedge, using the inputs that were stable before it.
    function automatic void model_edge();
        bit expired = 0;
        if (m_tick) m_ms = (m_ms + 1) % 65536;
        if (stop) begin
            m_run = 0; m_rem = 0;
        end else if (start) begin
            m_rem = period;
            m_run = (period != 0);
            expired = (period == 0);
        end else if (m_run && m_tick) begin
            m_rem = m_rem - 1;
            if (m_rem == 0) begin
                expired = 1;
                if (auto_reload) m_rem = period;
                m_run = (m_rem != 0);
            end
        end
        m_done = m_pend;
        m_pend = expired;
        // A rise seen between two post-reset samples ticks two edges after it is sampled.
        s4 = s3; s3 = s2; s2 = s1; s1 = clk_1ms;
        if (n_edges < 10) n_edges++;
        m_tick = (n_edges >= 4) && s3 && !s4;
    endfunction

    task automatic compare_all();
        check_eq("tick", tick, m_tick);
        check_eq("busy", busy, m_run);
        check_eq("done", done, m_done);
        check_eq("remaining", remaining, m_rem);
        check_eq("ms_cnt", ms_cnt, m_ms);
        check_eq("tick8", tick8, m_tick);
        check_eq("busy8", busy8, m_run);
        check_eq("done8", done8, m_done);
        check_eq("remaining8", remaining8, m_rem % 256);
        check_eq("ms_cnt8", ms_cnt8, m_ms % 256);
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst) model_reset();
        else model_edge();
        #1;
        compare_all();
        if (tick) n_tick_seen++;
        if (done) n_done_seen++;
        if (busy) n_busy_seen++;
        if (wave_on) begin
            ph_left--;
            if (ph_left <= 0) begin
                clk_1ms = ~clk_1ms;
                ph_left = $urandom_range(ph_hi, ph_lo);
            end
        end
    endtask

    task automatic pulse_start(input int p, input bit ar);
        period = 16'(p); auto_reload = ar; start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic clear_counts();
        n_tick_seen = 0; n_done_seen = 0; n_busy_seen = 0;
    endtask

    initial begin
        bit found;
        rst = 1'b1; clk_1ms = 1'b1; start = 0; stop = 0; auto_reload = 0; period = '0;
        wave_on = 0; ph_lo = 4; ph_hi = 4; ph_left = 4;
        model_reset();
        #1;
        compare_all();
        repeat (3) cycle();
        rst = 1'b0;

        // clk_1ms already high at release: no tick
        clear_counts();
        repeat (20) cycle();
        check_eq("no_tick_at_release", n_tick_seen, 0);
        clk_1ms = 1'b0;
        repeat (5) cycle();
        clk_1ms = 1'b1;
        cycle();
        cycle();
        check_eq("tick_not_early", tick, 0);
        cycle();
        check_eq("tick_latency", tick, 1);
        cycle();
        check_eq("tick_width", tick, 0);
        check_eq("ms_cnt_first", ms_cnt, 1);

        // Countdown of 5, no reload
        wave_on = 1; clk_1ms = 1'b0; ph_left = 4;
        clear_counts();
        pulse_start(5, 0);
        for (int i = 0; i < 300 && (busy || n_done_seen == 0); i++) cycle();
        repeat (4) cycle();
        check_eq("p5_done_count", n_done_seen, 1);
        check_eq("p5_ticks", n_tick_seen >= 5, 1);

        // Auto-reload every 3 ticks, then stop
        clear_counts();
        pulse_start(3, 1);
        for (int i = 0; i < 400 && n_tick_seen < 9; i++) cycle();
        repeat (2) cycle();
        check_eq("ar_done_count", n_done_seen, 3);
        check_eq("ar_busy", busy, 1);
        stop = 1'b1; cycle(); stop = 1'b0;
        check_eq("stop_busy", busy, 0);
        check_eq("stop_rem", remaining, 0);
        clear_counts();
        repeat (60) cycle();
        check_eq("stop_no_done", n_done_seen, 0);

        // Zero period: done, never busy
        clear_counts();
        pulse_start(0, 0);
        repeat (4) cycle();
        check_eq("p0_done", n_done_seen, 1);
        check_eq("p0_busy", n_busy_seen, 0);

        // start+stop together while running
        pulse_start(6, 0);
        repeat (3) cycle();
        period = 16'd4; start = 1'b1; stop = 1'b1;
        cycle();
        start = 1'b0; stop = 1'b0;
        check_eq("ss_busy", busy, 0);
        check_eq("ss_rem", remaining, 0);

        // Randomized traffic with varied clk_1ms phases
        ph_lo = 3; ph_hi = 7;
        for (int i = 0; i < 4000; i++) begin
            start = ($urandom_range(39, 0) == 0);
            stop = ($urandom_range(79, 0) == 0);
            period = 16'($urandom_range(6, 0));
            auto_reload = 1'($urandom_range(1, 0));
            cycle();
        end
        start = 0; stop = 0;

        // Reset while running with remaining=2 and a tick in flight
        ph_lo = 4; ph_hi = 4;
        pulse_start(3, 0);
        found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            if (m_run && m_rem == 2 && s1 && !s2) found = 1;
            else begin
                if (!m_run) begin
                    period = 16'd3; start = 1'b1;
                end
                cycle();
                start = 1'b0;
            end
        end
        check_eq("inflight_found", found, 1);
        rst = 1'b1;
        #1;
        model_reset();
        check_eq("rst_tick", tick, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_rem", remaining, 0);
        check_eq("rst_ms", ms_cnt, 0);
        clear_counts();
        repeat (4) cycle();
        rst = 1'b0;
        repeat (40) cycle();
        check_eq("rst_no_done", n_done_seen, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
